ripple_add_sequencer: RTL and testbench
=======================================

// Module: ripple_add_sequencer
// PURPOSE
//  Sequencer that performs wide (N*WORDS-bit) additions on one shared N-bit ripple-carry adder slice.
//  Operates one N-bit chunk per clock, LSB chunk first, and chains the carry through a register.
//  Sits between an operand producer and a result consumer; valid/ready handshake on both sides.
//  Trades latency (WORDS cycles) for area versus a full-width flat adder.
// PARAMETERS
//  N      4  chunk width = width of the internal ripple adder slice (>=1)
//  WORDS  4  chunks per operand; operand width W = N*WORDS (>=1)
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operand request valid
//  in_ready   out  1  sequencer can accept operands
//  in_a       in   W  operand A
//  in_b       in   W  operand B
//  in_cin     in   1  carry-in for chunk 0
//  in_sub     in   1  subtract select (port exists only with RIPPLE_ADD_SUB_EN)
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  out_sum    out  W  result
//  out_cout   out  1  carry out of the top chunk
//  busy       out  1  high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1 after reset release; out_valid=0, out_sum=0,
//    out_cout=0, busy=0; chunk index and carry reg cleared. Reset mid-RUN aborts with no result.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&in_ready at edge k: capture in_a, in_b, carry reg<=in_cin, idx<=0,
//      go RUN. Later operand changes ignored.
//    RUN: in_ready=0. Each edge: out_sum[idx*N +: N] <= A_chunk+B_chunk+carry (mod 2^N);
//      carry reg <= chunk carry-out; idx++. At the edge processing idx=WORDS-1: out_cout <= carry-out,
//      out_valid<=1, go DONE.
//    DONE: out_valid=1, out_sum/out_cout stable. out_valid&out_ready: out_valid<=0, go IDLE.
//      in_ready stays 0 in DONE: no accept in the same cycle as result handoff.
//  - Latency: out_valid high exactly WORDS cycles after the accept edge. Throughput: one op per
//    WORDS+2 cycles minimum (accept, WORDS RUN edges, handoff).
//  - Result equals (A + B + cin) mod 2^W; out_cout equals bit W of the full sum.
//  - WORDS=1: RUN lasts one cycle; idx does not wrap. idx width = max(1,clog2(WORDS)).
//  - out_ready high outside DONE is ignored. in_valid low in IDLE: remain IDLE, all outputs held.
//  - Chunk adder is a structural per-bit ripple (xor/and/or full-adder per bit, generate loop).
// CONFIGURATION
//  RIPPLE_ADD_SUB_EN defined: in_sub port present. If in_sub=1 at accept, B is captured inverted
//    and the chunk-0 carry is forced to 1 (in_cin ignored); result = A - B mod 2^W;
//    out_cout=1 means no borrow. in_sub=0 gives plain addition.
//  Not defined: no in_sub port; add only; no inversion logic synthesised.
// TESTING (N=4, WORDS=4)
//  1. in_a=0x00FF, in_b=0x0001, cin=0 -> out_sum=0x0100, out_cout=0, out_valid 4 cycles after accept.
//  2. in_a=0xFFFF, in_b=0x0001, cin=0 -> out_sum=0x0000, out_cout=1 (full carry ripple).
//  3. in_a=0x1234, in_b=0x1111, cin=1; out_ready low 5 cycles -> out_sum=0x2346 held stable,
//     in_ready=0 throughout; after handoff in_ready=1 next cycle.
//  4. Accept 0xAAAA+0x5555, drop rst_n after 2 RUN cycles -> immediately out_valid=0,
//     out_sum=0, busy=0; after release next op 0x0001+0x0001 -> 0x0002.
//  5. Back-to-back ops with in_valid held high -> accepts spaced by WORDS+2 cycles, no op lost.
//  6. RIPPLE_ADD_SUB_EN: in_a=0x0005, in_b=0x0007, in_sub=1 -> out_sum=0xFFFE, out_cout=0;
//     in_a=0x0007, in_b=0x0005 -> 0x0002, out_cout=1.

Source files
------------

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer: wide (N*WORDS-bit) adder built from one shared N-bit
// ripple-carry slice, one chunk per clock, LSB chunk first, carry chained
// through a register. valid/ready handshake on operand and result sides.
// Optional feature macro: RIPPLE_ADD_SUB_EN adds the in_sub port (A - B).
//
// state  | meaning
// IDLE   | waiting for operands, in_ready=1
// RUN    | adding chunk idx_q, one chunk per clock
// DONE   | result valid, held until out_ready
module ripple_add_sequencer #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_cin,
`ifdef RIPPLE_ADD_SUB_EN
    input  logic               in_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               busy
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     a_chunk;
    logic [N-1:0]     b_chunk;
    logic [N-1:0]     chunk_sum;
    logic [N:0]       rip_c;

    // Select the operand chunks addressed by the current chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                a_chunk = a_q[w*N +: N];
                b_chunk = b_q[w*N +: N];
            end
        end
    end

    // Shared N-bit slice: one full adder per bit, carry rippling upward.
    assign rip_c[0] = carry_q;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign chunk_sum[i] = a_chunk[i] ^ b_chunk[i] ^ rip_c[i];
        assign rip_c[i+1]   = (a_chunk[i] & b_chunk[i]) |
                              (rip_c[i] & (a_chunk[i] ^ b_chunk[i]));
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = in_a;
`ifdef RIPPLE_ADD_SUB_EN
                    // Subtraction as A + ~B + 1; the +1 replaces in_cin.
                    b_d        = in_sub ? ~in_b : in_b;
                    carry_d    = in_sub | in_cin;
`else
                    b_d        = in_b;
                    carry_d    = in_cin;
`endif
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        sum_d[w*N +: N] = chunk_sum;
                    end
                end
                carry_d = rip_c[N];
                if (idx_q == IDX_LAST) begin
                    // Index parks at zero so WORDS=1 never wraps past the last chunk.
                    idx_d       = '0;
                    cout_d      = rip_c[N];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                // in_ready stays low here: the next accept waits one cycle after handoff.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Testbench for ripple_add_sequencer (N=4, WORDS=4): directed operations,
// a cycle-level arithmetic model checked every cycle, and literal expectations.
module tb_ripple_add_sequencer;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub_drv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic         sub_eff;

    int n_tests;
    int n_fail;
    int res_cnt;

    ripple_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef RIPPLE_ADD_SUB_EN
        .in_sub    (in_sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

`ifdef RIPPLE_ADD_SUB_EN
    assign sub_eff = in_sub_drv;
`else
    assign sub_eff = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: result is plain (W+1)-bit arithmetic, ready WORDS cycles after accept.
    int           m_phase;
    int           m_left;
    logic         m_valid;
    logic         m_ready;
    logic         m_busy;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic [W:0]   m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_valid <= 1'b0;
            m_ready <= 1'b1;
            m_busy  <= 1'b0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    if (sub_eff)
                        m_res <= {1'b0, in_a} + {1'b0, ~in_b} + (W+1)'(1);
                    else
                        m_res <= {1'b0, in_a} + {1'b0, in_b} + (W+1)'(in_cin);
                    m_left  <= WORDS;
                    m_phase <= 1;
                    m_ready <= 1'b0;
                    m_busy  <= 1'b1;
                end
                1: begin
                    if (m_left == 1) begin
                        m_valid <= 1'b1;
                        m_sum   <= m_res[W-1:0];
                        m_cout  <= m_res[W];
                        m_phase <= 2;
                    end
                    m_left <= m_left - 1;
                end
                default: if (out_ready) begin
                    m_valid <= 1'b0;
                    m_ready <= 1'b1;
                    m_busy  <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Compare DUT to model on every falling edge.
    always @(negedge clk) begin
        chk("model out_valid", 32'(out_valid), 32'(m_valid));
        chk("model in_ready", 32'(in_ready), 32'(m_ready));
        chk("model busy", 32'(busy), 32'(m_busy));
        if (m_valid || !rst_n) begin
            chk("model out_sum", 32'(out_sum), 32'(m_sum));
            chk("model out_cout", 32'(out_cout), 32'(m_cout));
        end
        if (out_valid && out_ready) res_cnt++;
    end

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input int hold,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
        int t;
        int lat;
        @(negedge clk);
        in_a       = a;
        in_b       = b;
        in_cin     = cin;
        in_sub_drv = sub;
        in_valid   = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({name, " accept ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_cin   = ~cin;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(WORDS));
        chk({name, " sum"}, 32'(out_sum), 32'(exp_sum));
        chk({name, " cout"}, 32'(out_cout), 32'(exp_cout));
        repeat (hold) begin
            @(negedge clk);
            chk({name, " held sum"}, 32'(out_sum), 32'(exp_sum));
            chk({name, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        in_sub_drv = 1'b0;
        chk({name, " post handoff valid"}, 32'(out_valid), 32'd0);
        chk({name, " post handoff in_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [W-1:0] b2b_a [3];
    logic [W-1:0] b2b_b [3];
    logic         b2b_c [3];

    initial begin
        int t;
        int gap;
        n_tests    = 0;
        n_fail     = 0;
        res_cnt    = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        in_sub_drv = 1'b0;
        out_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum", 32'(out_sum), 32'd0);
        chk("reset out_cout", 32'(out_cout), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset release in_ready", 32'(in_ready), 32'd1);

        // Idle with out_ready high and no operands: nothing happens.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        chk("idle out_valid", 32'(out_valid), 32'd0);

        do_op("t1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0);
        do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1);
        do_op("t3", 16'h1234, 16'h1111, 1'b1, 1'b0, 5, 16'h2346, 1'b0);

        // Reset in the middle of RUN.
        @(negedge clk);
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4 abort out_valid", 32'(out_valid), 32'd0);
        chk("t4 abort out_sum", 32'(out_sum), 32'd0);
        chk("t4 abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("t4", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0);

        // Back-to-back operations with in_valid and out_ready held high.
        b2b_a[0] = 16'h0F0F; b2b_b[0] = 16'h0101; b2b_c[0] = 1'b0;
        b2b_a[1] = 16'h8000; b2b_b[1] = 16'h8000; b2b_c[1] = 1'b1;
        b2b_a[2] = 16'hFFFF; b2b_b[2] = 16'hFFFF; b2b_c[2] = 1'b1;
        @(negedge clk);
        res_cnt   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a   = b2b_a[i];
            in_b   = b2b_b[i];
            in_cin = b2b_c[i];
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("t5 accept ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            if (i == 2) in_valid = 1'b0;
            gap = 1;
            while (!in_ready && gap < 50) begin
                @(negedge clk);
                gap++;
            end
            chk("t5 accept spacing", 32'(gap), 32'(WORDS + 2));
        end
        out_ready = 1'b0;
        chk("t5 results delivered", 32'(res_cnt), 32'd3);

`ifdef RIPPLE_ADD_SUB_EN
        do_op("t6 sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0);
        do_op("t6 sub 7-5", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1);
        do_op("t6 add", 16'h0007, 16'h0005, 1'b0, 1'b0, 0, 16'h000C, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
